// File: rtl/imem_loader_if.sv
// Host-side program load channel: start request plus a valid/ready word stream.
interface imem_loader_if;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned WORD_W = 32;

  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_last;
  logic              word_ready;

  modport master (
    output load_start, load_base, word_in, word_valid, word_last,
    input  word_ready
  );

  modport slave (
    input  load_start, load_base, word_in, word_valid, word_last,
    output word_ready
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: accepts 32-bit words from a host and writes them
// little-endian, one byte per cycle, into a 256-byte instruction memory while
// holding the core in reset.
module imem_loader (
  input  logic                clk,
  input  logic                reset,
  imem_loader_if.slave        bus,
  output logic [255:0][7:0]   i_mem,
  output logic                core_reset,
  output logic                load_done,
  output logic                overflow,
  output logic [6:0]          words_loaded
);
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned CNT_W     = 7;
  localparam int unsigned MAX_WORDS = 64;

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                last_q, last_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                ovf_d;
  logic                mem_we;
  logic [BYTE_W-1:0]   mem_byte;

  // State and control/status registers; all outputs derive from next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      wr_addr_q      <= '0;
      byte_cnt_q     <= '0;
      word_q         <= '0;
      last_q         <= 1'b0;
      words_loaded   <= '0;
      overflow       <= 1'b0;
      load_done      <= 1'b0;
      core_reset     <= 1'b1;
      bus.word_ready <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_addr_q      <= wr_addr_d;
      byte_cnt_q     <= byte_cnt_d;
      word_q         <= word_d;
      last_q         <= last_d;
      words_loaded   <= cnt_d;
      overflow       <= ovf_d;
      load_done      <= (state_d == DONE);
      core_reset     <= !((state_d == ACCEPT) || (state_d == WRITE));
      bus.word_ready <= (state_d == ACCEPT);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    last_d     = last_q;
    cnt_d      = words_loaded;
    ovf_d      = overflow;
    mem_we     = 1'b0;
    mem_byte   = BYTE_W'(word_q >> {byte_cnt_q, 3'b000});

    case (state_q)
      IDLE, DONE: begin
        if (bus.load_start) begin
          state_d   = ACCEPT;
          wr_addr_d = {bus.load_base[ADDR_W-1:2], 2'b00};
          cnt_d     = '0;
          ovf_d     = 1'b0;
        end
      end
      ACCEPT: begin
        if (bus.word_valid && bus.word_ready) begin
          word_d     = bus.word_in;
          last_d     = bus.word_last;
          byte_cnt_d = '0;
          state_d    = WRITE;
        end
      end
      WRITE: begin
        mem_we     = 1'b1;
        wr_addr_d  = wr_addr_q + ADDR_W'(1);
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) begin
          if (words_loaded != CNT_W'(MAX_WORDS)) cnt_d = words_loaded + CNT_W'(1);
          if (last_q) begin
            state_d = DONE;
          end else if (wr_addr_q == {ADDR_W{1'b1}}) begin
            state_d = DONE;
            ovf_d   = 1'b1;
          end else begin
            state_d = ACCEPT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Instruction memory image; cleared by reset, written one byte per WRITE cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      i_mem <= '0;
    end else if (mem_we) begin
      i_mem[wr_addr_q] <= mem_byte;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: host word stream with a scoreboard of
// expected (address, word) pairs and a reference byte image of the memory.
module tb_imem_loader;
  logic             clk = 1'b0;
  logic             reset;
  logic [255:0][7:0] i_mem;
  logic             core_reset;
  logic             load_done;
  logic             overflow;
  logic [6:0]       words_loaded;

  imem_loader_if bus ();

  imem_loader dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .i_mem        (i_mem),
    .core_reset   (core_reset),
    .load_done    (load_done),
    .overflow     (overflow),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] word;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] ref_mem [256];
  logic [7:0] addr_m;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < 256; i++) if (i_mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    sb_q.delete();
  endtask

  // Pop every expected word and compare against a fetch-style little-endian read.
  task automatic sb_drain(input string tag);
    exp_t       e;
    logic [7:0] a0, a1, a2, a3;
    while (sb_q.size() > 0) begin
      e  = sb_q.pop_front();
      a0 = e.addr;
      a1 = a0 + 8'd1;
      a2 = a0 + 8'd2;
      a3 = a0 + 8'd3;
      check(tag, {i_mem[a3], i_mem[a2], i_mem[a1], i_mem[a0]}, e.word);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset          = 1'b0;
    bus.load_start = 1'b1;
    bus.word_valid = 1'b1;
    @(negedge clk);
    reset          = 1'b1;
    bus.load_start = 1'b0;
    bus.word_valid = 1'b0;
    model_clear();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, bus.word_ready, 1'b0);
    check({tag, "_core_reset"}, core_reset, 1'b1);
    check({tag, "_done"}, load_done, 1'b0);
    check({tag, "_ovf"}, overflow, 1'b0);
    check({tag, "_wl"}, words_loaded, 7'd0);
    check({tag, "_mem_zero"}, mem_diff(), 0);
  endtask

  task automatic start_load(input logic [7:0] base);
    @(negedge clk);
    bus.load_start = 1'b1;
    bus.load_base  = base;
    @(negedge clk);
    bus.load_start = 1'b0;
    addr_m = {base[7:2], 2'b00};
  endtask

  // Offer one word; with junk set, valid is randomised and garbage plus stray
  // load_start pulses are driven while the loader is busy.
  task automatic send_word(input logic [31:0] w, input bit last, input bit junk,
                           input int bound, output bit ok);
    bit v;
    ok = 1'b0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      bus.load_start = 1'b0;
      if (bus.word_ready) begin
        v = junk ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.word_in    = w;
        bus.word_last  = last;
        bus.word_valid = v;
        if (v) begin
          @(posedge clk);
          ok = 1'b1;
          sb_q.push_back('{addr: addr_m, word: w});
          for (int b = 0; b < 4; b++) ref_mem[8'(addr_m + 8'(b))] = 8'(w >> (8 * b));
          addr_m = addr_m + 8'd4;
          return;
        end
      end else if (junk) begin
        bus.word_in    = $urandom;
        bus.word_last  = 1'($urandom_range(0, 1));
        bus.word_valid = 1'($urandom_range(0, 1));
        bus.load_start = ($urandom_range(0, 3) == 0);
      end else begin
        bus.word_valid = 1'b0;
      end
    end
  endtask

  task automatic idle_bus();
    @(negedge clk);
    bus.word_valid = 1'b0;
    bus.word_last  = 1'b0;
    bus.load_start = 1'b0;
  endtask

  // Count edges, starting with the accepting edge as 1, until load_done shows.
  task automatic wait_done(input int bound, output int lat);
    lat = 1;
    for (int c = 0; c < bound; c++) begin
      @(posedge clk);
      #1;
      lat++;
      if (load_done) return;
    end
    check("done_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    bit          ok;
    int          lat;
    logic [31:0] w;

    reset          = 1'b0;
    bus.load_start = 1'b0;
    bus.load_base  = 8'h00;
    bus.word_in    = 32'h0;
    bus.word_valid = 1'b0;
    bus.word_last  = 1'b0;
    model_clear();
    addr_m = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check_reset_state("por");

    // Single word at base 0 with last.
    start_load(8'h00);
    check("accept_ready", bus.word_ready, 1'b1);
    check("accept_core_reset", core_reset, 1'b0);
    send_word(32'h8C220004, 1'b1, 1'b0, 20, ok);
    check("w0_accepted", ok, 1'b1);
    #1;
    check("write_core_reset", core_reset, 1'b0);
    check("write_ready", bus.word_ready, 1'b0);
    wait_done(20, lat);
    check("done_latency", lat, 5);
    idle_bus();
    check("w0_done", load_done, 1'b1);
    check("w0_core_reset", core_reset, 1'b1);
    check("w0_wl", words_loaded, 7'd1);
    check("w0_ovf", overflow, 1'b0);
    check("w0_bytes", {i_mem[0], i_mem[1], i_mem[2], i_mem[3]}, 32'h0400228C);
    sb_drain("w0_sb");

    // Unaligned base: low address bits dropped.
    start_load(8'h13);
    check("restart_done_clr", load_done, 1'b0);
    send_word(32'hA1B2C3D4, 1'b1, 1'b0, 20, ok);
    wait_done(20, lat);
    idle_bus();
    check("b13_byte10", i_mem[8'h10], 8'hD4);
    sb_drain("b13_sb");
    check("b13_image", mem_diff(), 0);

    // Run off the top of memory with no last word.
    start_load(8'hF8);
    send_word(32'h11223344, 1'b0, 1'b0, 20, ok);
    check("ov_w1_acc", ok, 1'b1);
    send_word(32'h55667788, 1'b0, 1'b0, 20, ok);
    check("ov_w2_acc", ok, 1'b1);
    send_word(32'h99AABBCC, 1'b0, 1'b0, 20, ok);
    check("ov_w3_rejected", ok, 1'b0);
    idle_bus();
    check("ov_flag", overflow, 1'b1);
    check("ov_done", load_done, 1'b1);
    check("ov_wl", words_loaded, 7'd2);
    check("ov_ready", bus.word_ready, 1'b0);
    sb_drain("ov_sb");
    check("ov_image", mem_diff(), 0);

    // Last word ends exactly at byte 255: no overflow.
    start_load(8'hFC);
    check("fc_ovf_clr", overflow, 1'b0);
    send_word(32'hDEADBEEF, 1'b1, 1'b0, 20, ok);
    wait_done(20, lat);
    idle_bus();
    check("fc_ovf", overflow, 1'b0);
    check("fc_done", load_done, 1'b1);
    sb_drain("fc_sb");

    // Random valid, garbage and stray load_start while busy.
    start_load(8'h80);
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      send_word(w, (i == 7), 1'b1, 200, ok);
      check("rnd_acc", ok, 1'b1);
    end
    wait_done(20, lat);
    idle_bus();
    check("rnd_done", load_done, 1'b1);
    check("rnd_wl", words_loaded, 7'd8);
    check("rnd_ovf", overflow, 1'b0);
    sb_drain("rnd_sb");
    check("rnd_image", mem_diff(), 0);

    // Reset during the second WRITE cycle aborts and clears everything.
    start_load(8'h40);
    send_word(32'hCAFEF00D, 1'b1, 1'b0, 20, ok);
    @(posedge clk);
    apply_reset();
    check_reset_state("midrst");
    repeat (2) @(negedge clk);
    check("midrst_idle_ready", bus.word_ready, 1'b0);
    check("midrst_idle_done", load_done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
